// File: rtl/minaret_pkg.sv
// Shared types for the minaret memory arbiter: FSM states, port identifiers
// and the RAM read latency the response timing is built around.
package minaret_pkg;

   typedef enum logic {IDLE, RESP} state_t;

   typedef enum logic {PORT_I, PORT_D} port_t;

   localparam int MEM_LAT = 1;

endpackage

// File: rtl/minaret_rr_arb.sv
// Two-way round-robin between the instruction and data ports; the last
// granted port loses the next tie, and history only moves on a real grant.
module minaret_rr_arb
   import minaret_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_i,
   input  logic req_d,
   input  logic en,
   output logic gnt_i,
   output logic gnt_d
);

   port_t last;

   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (en) begin
         if (req_d && (!req_i || last == PORT_I)) begin
            gnt_d = 1'b1;
         end else if (req_i) begin
            gnt_i = 1'b1;
         end
      end
   end

   // Starting at PORT_I lets the data port win the first tie after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last <= PORT_I;
      end else if (gnt_d) begin
         last <= PORT_D;
      end else if (gnt_i) begin
         last <= PORT_I;
      end
   end

endmodule

// File: rtl/minaret_memarb.sv
// Merges the core's imem and dmem valid/ready ports onto one single-port RAM
// with one-cycle read latency; every access takes a grant cycle and a response cycle.
module minaret_memarb
   import minaret_pkg::*;
#(
   parameter int MEM_WORDS = 65536,
   localparam int ADDR_W = $clog2(MEM_WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              imem_valid,
   input  logic [31:0]       imem_addr,
   output logic              imem_ready,
   output logic [31:0]       imem_rdata,
   input  logic              dmem_valid,
   input  logic [31:0]       dmem_addr,
   input  logic [3:0]        dmem_wmask,
   input  logic [31:0]       dmem_wdata,
   input  logic [3:0]        dmem_rmask,
   output logic              dmem_ready,
   output logic [31:0]       dmem_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              bus_err
);

   state_t      state;
   state_t      state_next;
   port_t       sel;
   port_t       sel_next;
   logic        err;
   logic        err_next;
   logic        rd;
   logic        rd_next;
   logic        arb_en;
   logic        gnt_i;
   logic        gnt_d;
   logic [31:0] req_addr;
   logic        oor;
   logic [31:0] resp_data;
   logic        unused;

   // Gating with reset keeps the combinational grant path quiet while reset is held.
   assign arb_en = (state == IDLE) && reset;

   minaret_rr_arb u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i (imem_valid),
      .req_d (dmem_valid),
      .en    (arb_en),
      .gnt_i (gnt_i),
      .gnt_d (gnt_d)
   );

   assign req_addr = gnt_d ? dmem_addr : imem_addr;
   assign oor      = |req_addr[31:ADDR_W+2];
   assign unused   = ^{dmem_rmask, req_addr[1:0]};

   // Request fields are only looked at in the grant cycle; out-of-range
   // accesses never reach the RAM but still get a (failing) response.
   always_comb begin
      state_next = state;
      sel_next   = sel;
      err_next   = err;
      rd_next    = rd;
      mem_en     = 1'b0;
      mem_we     = 4'b0;
      mem_addr   = '0;
      mem_wdata  = 32'b0;
      case (state)
         IDLE: begin
            if (gnt_i || gnt_d) begin
               state_next = RESP;
               sel_next   = gnt_d ? PORT_D : PORT_I;
               err_next   = oor;
               rd_next    = !gnt_d || (dmem_wmask == 4'b0);
               if (!oor) begin
                  mem_en   = 1'b1;
                  mem_addr = req_addr[ADDR_W+1:2];
                  if (gnt_d) begin
                     mem_we    = dmem_wmask;
                     mem_wdata = dmem_wdata;
                  end
               end
            end
         end
         RESP: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         sel   <= PORT_I;
         err   <= 1'b0;
         rd    <= 1'b0;
      end else begin
         state <= state_next;
         sel   <= sel_next;
         err   <= err_next;
         rd    <= rd_next;
      end
   end

   assign imem_ready = (state == RESP) && (sel == PORT_I);
   assign dmem_ready = (state == RESP) && (sel == PORT_D);
   assign bus_err    = (state == RESP) && err;
   assign resp_data  = (rd && !err) ? mem_rdata : 32'b0;
   assign imem_rdata = imem_ready ? resp_data : 32'b0;
   assign dmem_rdata = dmem_ready ? resp_data : 32'b0;

endmodule

// File: tb/tb_minaret_memarb.sv
// Randomized bench for minaret_memarb: a behavioural RAM, core-like drivers and
// a transaction-level reference model that predicts every cycle's outputs.
module tb_minaret_memarb;
   import minaret_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_valid;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        dmem_valid;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_rmask;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   minaret_memarb #(.MEM_WORDS(65536)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_valid (imem_valid),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .dmem_valid (dmem_valid),
      .dmem_addr  (dmem_addr),
      .dmem_wmask (dmem_wmask),
      .dmem_wdata (dmem_wdata),
      .dmem_rmask (dmem_rmask),
      .dmem_ready (dmem_ready),
      .dmem_rdata (dmem_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .bus_err    (bus_err)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM with one-cycle read latency.
   logic [31:0] ram [0:65535];

   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
         mem_rdata <= ram[mem_addr];
      end
   end

   // Reference model state: pending response and the last-granted port.
   logic [31:0] ref_mem [int];
   bit          m_resp;
   bit          m_port_d;
   bit          m_last_d;
   bit          m_err;
   logic [31:0] m_data;

   int          mode;
   bit          done_i;
   bit          done_d;
   logic [31:0] last_irdata;
   logic [31:0] last_drdata;
   logic        last_err;
   int          cyc;
   logic [7:0]  hist_i;
   logic [7:0]  hist_d;

   function automatic logic [31:0] initWord(input int w);
      if (w == 32'h40) return 32'h0000_0013;
      if (w == 32'h800) return 32'h1122_3344;
      return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] refRead(input int w);
      if (ref_mem.exists(w)) return ref_mem[w];
      return initWord(w);
   endfunction

   function automatic void refWrite(input int w, input logic [3:0] wm, input logic [31:0] wd);
      logic [31:0] v;
      v = refRead(w);
      for (int b = 0; b < 4; b++) begin
         if (wm[b]) v[8*b +: 8] = wd[8*b +: 8];
      end
      ref_mem[w] = v;
   endfunction

   function automatic logic [31:0] randAddr();
      if ($urandom_range(0, 7) == 0)
         return (32'($urandom_range(1, 16383)) << 18) | (32'($urandom_range(0, 255)) << 2);
      return 32'h100 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic newI();
      imem_valid = 1'b1;
      imem_addr  = randAddr();
   endtask

   task automatic newD();
      dmem_valid = 1'b1;
      dmem_addr  = randAddr();
      dmem_wmask = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      dmem_wdata = $urandom;
      dmem_rmask = 4'($urandom_range(0, 15));
   endtask

   task automatic modelReset();
      m_resp   = 1'b0;
      m_last_d = 1'b0;
      done_i   = 1'b0;
      done_d   = 1'b0;
   endtask

   // One clock: predict and check at the falling edge, then let the core-side
   // drivers react just after the rising edge.
   task automatic stepCycle();
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_data;
      logic [3:0]  wm;
      bit          g_i;
      bit          g_d;
      bit          oor;
      int          word;
      @(negedge clk);
      if (m_resp) begin
         checkOutput("imem_ready", {31'b0, imem_ready}, {31'b0, !m_port_d});
         checkOutput("dmem_ready", {31'b0, dmem_ready}, {31'b0, m_port_d});
         checkOutput("imem_rdata", imem_rdata, m_port_d ? 32'b0 : m_data);
         checkOutput("dmem_rdata", dmem_rdata, m_port_d ? m_data : 32'b0);
         checkOutput("bus_err", {31'b0, bus_err}, {31'b0, m_err});
         checkOutput("mem_en_resp", {31'b0, mem_en}, 32'b0);
         m_resp = 1'b0;
      end else begin
         checkOutput("ready_idle", {30'b0, imem_ready, dmem_ready}, 32'b0);
         checkOutput("bus_err_idle", {31'b0, bus_err}, 32'b0);
         g_d = dmem_valid && (!imem_valid || !m_last_d);
         g_i = imem_valid && !g_d;
         if (g_i || g_d) begin
            a    = g_d ? dmem_addr : imem_addr;
            wm   = g_d ? dmem_wmask : 4'b0;
            wd   = dmem_wdata;
            oor  = (a >> 18) != 0;
            word = int'((a >> 2) & 32'hFFFF);
            checkOutput("mem_en", {31'b0, mem_en}, {31'b0, !oor});
            exp_data = 32'b0;
            if (!oor) begin
               checkOutput("mem_addr", {16'b0, mem_addr}, 32'(word));
               checkOutput("mem_we", {28'b0, mem_we}, {28'b0, wm});
               if (wm != 0) begin
                  checkOutput("mem_wdata", mem_wdata, wd);
                  refWrite(word, wm, wd);
               end else begin
                  exp_data = refRead(word);
               end
            end else begin
               checkOutput("mem_we_oor", {28'b0, mem_we}, 32'b0);
            end
            m_resp   = 1'b1;
            m_port_d = g_d;
            m_err    = oor;
            m_data   = exp_data;
            m_last_d = g_d;
         end else begin
            checkOutput("mem_en_idle", {31'b0, mem_en}, 32'b0);
         end
      end
      if (imem_ready) begin
         done_i      = 1'b1;
         last_irdata = imem_rdata;
         last_err    = bus_err;
      end
      if (dmem_ready) begin
         done_d      = 1'b1;
         last_drdata = dmem_rdata;
         last_err    = bus_err;
      end
      if (cyc < 8) begin
         hist_i[cyc] = imem_ready;
         hist_d[cyc] = dmem_ready;
      end
      cyc++;
      @(posedge clk);
      #1;
      if (done_i) begin
         done_i     = 1'b0;
         imem_valid = 1'b0;
         if (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1)) newI();
      end else if (mode == 1 && !imem_valid && $urandom_range(0, 1) == 1) begin
         newI();
      end
      if (done_d) begin
         done_d     = 1'b0;
         dmem_valid = 1'b0;
         if (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1)) newD();
      end else if (mode == 1 && !dmem_valid && $urandom_range(0, 1) == 1) begin
         newD();
      end
   endtask

   task automatic runI(input logic [31:0] a);
      imem_addr  = a;
      imem_valid = 1'b1;
      for (int n = 0; n < 10 && imem_valid; n++) stepCycle();
      if (imem_valid) begin
         checkOutput("timeout_i", 32'b0, 32'b1);
         imem_valid = 1'b0;
      end
   endtask

   task automatic runD(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] wd);
      dmem_addr  = a;
      dmem_wmask = wm;
      dmem_wdata = wd;
      dmem_rmask = (wm == 4'b0) ? 4'hF : 4'h0;
      dmem_valid = 1'b1;
      for (int n = 0; n < 10 && dmem_valid; n++) stepCycle();
      if (dmem_valid) begin
         checkOutput("timeout_d", 32'b0, 32'b1);
         dmem_valid = 1'b0;
      end
   endtask

   task automatic drain();
      mode = 0;
      for (int n = 0; n < 20 && (imem_valid || dmem_valid); n++) stepCycle();
      if (imem_valid || dmem_valid) begin
         checkOutput("timeout_drain", 32'b0, 32'b1);
         imem_valid = 1'b0;
         dmem_valid = 1'b0;
      end
   endtask

   task automatic applyStimulus();
      // Reset holds every output low even with both ports requesting.
      reset      = 1'b1;
      imem_valid = 1'b1;
      imem_addr  = 32'h100;
      dmem_valid = 1'b1;
      dmem_addr  = 32'h2000;
      dmem_wmask = 4'hF;
      dmem_wdata = 32'hA5A5_A5A5;
      dmem_rmask = 4'h0;
      mode       = 0;
      cyc        = 100;
      #2 reset = 1'b0;
      #3;
      checkOutput("rst_ready", {30'b0, imem_ready, dmem_ready}, 32'b0);
      checkOutput("rst_rdata", imem_rdata | dmem_rdata, 32'b0);
      checkOutput("rst_bus_err", {31'b0, bus_err}, 32'b0);
      checkOutput("rst_mem_en", {31'b0, mem_en}, 32'b0);
      checkOutput("rst_mem_we", {28'b0, mem_we}, 32'b0);
      checkOutput("rst_mem_addr", {16'b0, mem_addr}, 32'b0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'b0);
      imem_valid = 1'b0;
      dmem_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      modelReset();

      runI(32'h100);
      checkOutput("tp_fetch", last_irdata, 32'h0000_0013);
      runD(32'h2000, 4'b0011, 32'hDEAD_BEEF);
      runD(32'h2000, 4'b0000, 32'h0);
      checkOutput("tp_load", last_drdata, 32'h1122_BEEF);
      runD(32'h0004_0000, 4'b0000, 32'h0);
      checkOutput("tp_oor_err", {31'b0, last_err}, 32'b1);
      checkOutput("tp_oor_rdata", last_drdata, 32'b0);
      runD(32'h0004_2000, 4'hF, 32'hFFFF_FFFF);
      runD(32'h2000, 4'b0000, 32'h0);
      checkOutput("tp_oor_store", last_drdata, 32'h1122_BEEF);

      // Continuous contention from a fresh reset: D, I, D, I.
      reset = 1'b0;
      mode  = 2;
      newI();
      newD();
      @(posedge clk);
      #1 reset = 1'b1;
      modelReset();
      cyc    = 0;
      hist_i = 8'b0;
      hist_d = 8'b0;
      repeat (8) stepCycle();
      checkOutput("rr_dmem_ready", {24'b0, hist_d}, 32'b0010_0010);
      checkOutput("rr_imem_ready", {24'b0, hist_i}, 32'b1000_1000);
      drain();

      // Reset during a response abandons it; dmem still wins the next tie.
      imem_valid = 1'b1;
      imem_addr  = 32'h104;
      dmem_valid = 1'b1;
      dmem_addr  = 32'h108;
      dmem_wmask = 4'hF;
      dmem_wdata = 32'h0BAD_F00D;
      stepCycle();
      reset = 1'b0;
      #1;
      checkOutput("midrst_ready", {30'b0, imem_ready, dmem_ready}, 32'b0);
      checkOutput("midrst_mem_en", {31'b0, mem_en}, 32'b0);
      checkOutput("midrst_bus_err", {31'b0, bus_err}, 32'b0);
      modelReset();
      @(posedge clk);
      #1 reset = 1'b1;
      stepCycle();
      checkOutput("post_rst_dmem_first", {31'b0, dmem_ready}, 32'b1);
      drain();
      runD(32'h108, 4'b0000, 32'h0);
      checkOutput("midrst_store_kept", last_drdata, 32'h0BAD_F00D);

      mode = 1;
      repeat (3000) stepCycle();
      drain();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = initWord(i);
      mem_rdata = 32'b0;
      applyStimulus();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
